// File: rtl/serial_arbiter_pkg.sv
// Shared types and default sizing for the two-requester serial arbiter.
package serial_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    typedef logic req_id_t;

    localparam int unsigned DefaultWordBits  = 8;
    localparam int unsigned DefaultQueueDepth = 8;
    localparam int unsigned DefaultTimeout   = 64;

endpackage

// File: rtl/serial_arbiter_rr_arbiter2.sv
// Two-way round-robin priority: on a tie the requester not served last wins.
module rr_arbiter2
    import serial_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == 1'b1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/serial_arbiter.sv
// Grants one of two serial requesters a whole word and forwards its strobed bits
// to a deserializer with one cycle of latency, aborting on a strobe timeout.
module serial_arbiter
    import serial_arbiter_pkg::*;
#(
    parameter int unsigned WORD_BITS   = DefaultWordBits,
    parameter int unsigned QUEUE_DEPTH = DefaultQueueDepth,
    parameter int unsigned TIMEOUT     = DefaultTimeout
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_in,
    input  logic [1:0] bit_in,
    input  logic [1:0] wr_in,
    input  logic       status_in,
    input  logic [3:0] len_in,
    output logic [1:0] grant_out,
    output logic       data_out,
    output logic       write_out,
    output logic       done_out,
    output logic       timeout_out
);

    localparam int unsigned CntW  = $clog2(WORD_BITS + 1);
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    state_t            state_q;
    req_id_t           last_q;
    req_id_t           win_q;
    logic [CntW-1:0]   cnt_q;
    logic [IdleW-1:0]  idle_q;
    logic [1:0]        rr_grant;
    logic              start;
    logic              strobe;
    logic              sbit;

    rr_arbiter2 u_rr (
        .req   (req_in),
        .last  (last_q),
        .grant (rr_grant)
    );

    always_comb begin
        start  = (req_in != 2'b00) && status_in && (32'(len_in) < QUEUE_DEPTH);
        strobe = wr_in[win_q];
        sbit   = bit_in[win_q];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            win_q       <= 1'b0;
            cnt_q       <= '0;
            idle_q      <= '0;
            grant_out   <= 2'b00;
            data_out    <= 1'b0;
            write_out   <= 1'b0;
            done_out    <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            data_out    <= 1'b0;
            write_out   <= 1'b0;
            done_out    <= 1'b0;
            timeout_out <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StShift;
                        grant_out <= rr_grant;
                        win_q     <= rr_grant[1];
                        cnt_q     <= '0;
                        idle_q    <= '0;
                    end
                end
                StShift: begin
                    // A strobe wins over an expiring timeout in the same cycle.
                    if (strobe) begin
                        data_out  <= sbit;
                        write_out <= 1'b1;
                        idle_q    <= '0;
                        if (cnt_q == CntW'(WORD_BITS - 1)) begin
                            state_q  <= StDone;
                            done_out <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
                        state_q     <= StIdle;
                        timeout_out <= 1'b1;
                        grant_out   <= 2'b00;
                        last_q      <= win_q;
                        cnt_q       <= '0;
                        idle_q      <= '0;
                    end else begin
                        idle_q <= idle_q + IdleW'(1);
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    grant_out <= 2'b00;
                    last_q    <= win_q;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_arbiter.md
SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 Parameter WORD_BITS, default 8: serial bits per word forwarded to the deserializer.
REQ-002 Parameter QUEUE_DEPTH, default 8: queue capacity in words.
REQ-003 Parameter TIMEOUT, default 64: max idle cycles between strobes of a granted word.
REQ-004 clock  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_in  in  2  per-requester word-send request, level.
REQ-007 bit_in  in  2  per-requester serial data bit.
REQ-008 wr_in  in  2  per-requester bit strobe, one-cycle pulse per bit.
REQ-009 status_in  in  1  deserializer ready for a new word.
REQ-010 len_in  in  4  current queue occupancy.
REQ-011 grant_out  out  2  one-hot grant, zero when idle.
REQ-012 data_out  out  1  serial bit to deserializer data_in.
REQ-013 write_out  out  1  bit strobe to deserializer write_in.
REQ-014 done_out  out  1  one-cycle pulse, word completed.
REQ-015 timeout_out  out  1  one-cycle pulse, word aborted by timeout.

Function
REQ-016 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-017 IDLE->SHIFT when any req_in bit set, status_in=1 and len_in<QUEUE_DEPTH; otherwise stay IDLE.
REQ-018 Winner chosen round-robin: single requester wins alone; both requesting, the one not served last wins.
REQ-019 grant_out registered, asserted from the first SHIFT cycle, held constant through SHIFT and DONE.
REQ-020 In SHIFT, each wr_in pulse of the granted requester yields data_out=bit_in and write_out=1 exactly one cycle later (1-cycle latency).
REQ-021 Strobes and bits from the non-granted requester are ignored and never reach write_out.
REQ-022 Bit counter, width clog2(WORD_BITS+1), increments per forwarded strobe; at WORD_BITS strobes, SHIFT->DONE.
REQ-023 DONE lasts one cycle: done_out=1, last-served pointer updated to the winner, grant_out cleared on exit, next state IDLE.
REQ-024 Idle counter resets on every granted strobe; reaching TIMEOUT cycles without a strobe in SHIFT -> IDLE, timeout_out pulses one cycle, grant_out cleared, last-served pointer updated to the aborting requester.
REQ-025 Requester dropping req_in mid-word does not abort; only timeout aborts.
REQ-026 write_out never asserts outside SHIFT or the cycle after the final strobe.
REQ-027 Strobe arriving in the same cycle the timeout expires is forwarded and the timeout is cancelled.
REQ-028 len_in=QUEUE_DEPTH (full) or status_in=0 blocks new grants but never interrupts a word in SHIFT.

Reset
REQ-029 Reset forces IDLE; grant_out=0, data_out=0, write_out=0, done_out=0, timeout_out=0, counters=0, last-served pointer=requester 1 (requester 0 wins the first tie).
REQ-030 Reset asserted mid-word drops the word immediately; no partial done_out/timeout_out pulse.

Structure
REQ-031 Shared package holds the FSM state enum, requester-id typedef and default WORD_BITS/QUEUE_DEPTH/TIMEOUT constants.
REQ-032 Round-robin priority logic is a separate sub-module rr_arbiter2 (req, last-served in; one-hot grant out).

Verification
REQ-033 Req0 only, status=1, len=0, send 8'b10011001 LSB-first with strobes 10 cycles apart -> grant_out=01, write_out echoes 8 bits one cycle late, done_out one pulse.
REQ-034 Both requesting after reset -> grant 01 first word, grant 10 second word, then 01 again.
REQ-035 Req1 strobes while req0 granted -> no write_out from req1; req1 granted after req0's done_out.
REQ-036 len_in=8 with req0 set -> no grant; len_in drops to 7 -> grant_out=01 next cycle.
REQ-037 Granted requester stops after 3 bits -> timeout_out pulses after 64 idle cycles, FSM IDLE, grant_out=0.
REQ-038 Reset asserted after 4 bits -> all outputs 0 next cycle; subsequent word from req0 completes normally.
